mem_boot_io: RTL and testbench
==============================

// Module: mem_boot_io
// PURPOSE
// Memory/I-O subsystem on the far side of the processor's memory port (we/addr/toMem/fromMem).
// Holds unified instruction+data RAM; at reset it boots that RAM from a host byte stream while
// holding the processor in reset, then serves processor reads/writes. One memory-mapped output
// port (byte FIFO to host) sits at IO_ADDR.
// PARAMETERS
// DEPTH       256    RAM words (16 bit); only addresses 0..DEPTH-1 map to RAM
// IO_ADDR     8'hFF  word address decoded as the I/O port (overrides RAM at that address)
// FIFO_DEPTH  4      output FIFO entries, power of 2, >=2
// PORTS
// clk         in   1   clock, all state on posedge
// rst         in   1   asynchronous, active-high reset
// load_valid  in   1   host boot byte valid
// load_data   in   8   host boot byte
// load_ready  out  1   boot byte accepted when load_valid&&load_ready
// cpu_rst     out  1   registered reset to processor; 1 during boot
// boot_done   out  1   registered; 1 once RAM image loaded
// cpu_we      in   1   processor write enable
// cpu_addr    in   16  processor word address
// cpu_wdata   in   16  processor write data
// cpu_rdata   out  16  read data, combinational from cpu_addr
// out_valid   out  1   output FIFO not empty
// out_data    out  8   FIFO head byte
// out_ready   in   1   host pops head when out_valid&&out_ready
// BEHAVIOUR
// - Reset (async, rst=1): state=LOAD_CNT, cpu_rst=1, boot_done=0, load_ready=1, FIFO empty
//   (out_valid=0, out_data=0), overflow=0, word counter=0. RAM contents NOT cleared.
// - load_ready = (state!=RUN). States: LOAD_CNT -> LOAD_HI -> LOAD_LO -> (LOAD_HI | RUN).
// - LOAD_CNT: accepted byte = word count N (0..IO_ADDR); N=0 -> RUN at that edge. N>IO_ADDR clamped to IO_ADDR.
// - LOAD_HI: accepted byte latched as high byte. LOAD_LO: accepted byte completes word;
//   RAM[ctr] <= {hi,lo}, ctr++; if ctr+1==N -> RUN, else LOAD_HI. No byte accepted -> state holds.
// - Entering RUN: same edge sets cpu_rst<=0, boot_done<=1. RUN is terminal until rst.
// - During boot cpu_we/cpu_addr ignored; cpu_rdata still reads RAM combinationally.
// - RUN read: cpu_addr==IO_ADDR -> {13'b0,overflow,full,empty}; cpu_addr<DEPTH -> RAM[cpu_addr];
//   else 16'h0000. Zero-latency (processor latches fromMem the cycle after driving addr).
// - RUN write (cpu_we=1): addr==IO_ADDR -> push cpu_wdata[7:0]; addr<DEPTH -> RAM write at
//   posedge; else dropped. Every cycle with cpu_we high is a separate write/push.
// - FIFO: push when full is dropped and sets sticky overflow, even with a same-cycle pop.
//   Simultaneous push+pop when not full: both take effect, count unchanged. Pushed byte
//   visible on out_data/out_valid next cycle if FIFO was empty. Pointers wrap mod FIFO_DEPTH.
// - overflow cleared only by rst. Reads of IO_ADDR never pop.
// - rst mid-boot: partial image left in RAM; next accepted byte is a fresh count.
// STRUCTURE
// - proc_pkg: boot_state_t enum {LOAD_CNT,LOAD_HI,LOAD_LO,RUN}, IO_ADDR default constant.
// - Sub-module sync_fifo (W=8, FIFO_DEPTH): push/pop/full/empty/head, async active-high rst.
// - Top: boot FSM, word counter, hi-byte reg, RAM array, address decode, read mux.
// TESTING
// - Boot bytes 02,C1,2A,77,77 -> RAM[0]=C12A, RAM[1]=7777; cpu_rst/load_ready fall and
//   boot_done rises on edge accepting 5th byte; load_valid gaps stall without corruption.
// - Boot count 00 -> boot_done=1, cpu_rst=0 on the accepting edge; RAM unchanged.
// - RUN: we=1 addr=00FF wdata=0041 one cycle -> next cycle out_valid=1,out_data=41;
//   out_ready=1 -> out_valid=0 following cycle; read 00FF returns 0001 (empty).
// - out_ready=0, push 11,22,33,44,55 -> 55 dropped, read 00FF = 0006; drain yields 11,22,33,44.
// - Reset after count 03 and one word -> LOAD_CNT, cpu_rst=1, load_ready=1; next byte 01 = count.
// - RUN: write BEEF to 0010, read 0010 -> BEEF; write to 0123 ignored, read 0123 -> 0000.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types and constants for the boot-loading memory/I-O subsystem.
package proc_pkg;

    typedef enum logic [1:0] {
        LoadCnt,
        LoadHi,
        LoadLo,
        Run
    } boot_state_t;

    localparam logic [15:0] IoAddrDefault = 16'h00FF;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is dropped even if a pop happens the same cycle.
module sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are PW bits wide, so they wrap mod DEPTH for free.
    always_comb begin
        wr_d  = wr_q + PW'(do_push);
        rd_d  = rd_q + PW'(do_pop);
        cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_q] <= wdata;
            end
        end
    end

endmodule

// File: rtl/mem_boot_io.sv
// Unified RAM booted from a host byte stream while the processor is held in reset,
// then serving processor reads/writes with a memory-mapped output FIFO at IO_ADDR.
module mem_boot_io
    import proc_pkg::*;
#(
    parameter int unsigned DEPTH      = 256,
    parameter logic [15:0] IO_ADDR    = IoAddrDefault,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    output logic        cpu_rst,
    output logic        boot_done,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready
);
    localparam int unsigned AW = $clog2(DEPTH);

    boot_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, ctr_q, ctr_d, hi_q, hi_d;
    logic        cpu_rst_q, cpu_rst_d, boot_done_q, boot_done_d, ovf_q, ovf_d;
    logic [15:0] ram [DEPTH];
    logic        ram_we;
    logic [AW-1:0] ram_waddr;
    logic [15:0] ram_wdata;
    logic        push, pop, fifo_full, fifo_empty, accept, addr_in_ram;
    logic [7:0]  cnt_in;

    assign accept      = load_valid && (state_q != Run);
    assign addr_in_ram = 32'(cpu_addr) < DEPTH;
    assign cnt_in      = ({8'h00, load_data} > IO_ADDR) ? IO_ADDR[7:0] : load_data;
    assign load_ready  = (state_q != Run);
    assign cpu_rst     = cpu_rst_q;
    assign boot_done   = boot_done_q;
    assign pop         = out_ready && !fifo_empty;
    assign out_valid   = !fifo_empty;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ctr_d     = ctr_q;
        hi_d      = hi_q;
        ram_we    = 1'b0;
        ram_waddr = AW'(cpu_addr);
        ram_wdata = cpu_wdata;
        push      = 1'b0;
        unique case (state_q)
            LoadCnt: if (accept) begin
                cnt_d   = cnt_in;
                ctr_d   = 8'd0;
                state_d = (cnt_in == 8'd0) ? Run : LoadHi;
            end
            LoadHi: if (accept) begin
                hi_d    = load_data;
                state_d = LoadLo;
            end
            LoadLo: if (accept) begin
                ram_we    = 32'(ctr_q) < DEPTH;
                ram_waddr = AW'(ctr_q);
                ram_wdata = {hi_q, load_data};
                ctr_d     = ctr_q + 8'd1;
                state_d   = (ctr_q + 8'd1 == cnt_q) ? Run : LoadHi;
            end
            Run: if (cpu_we) begin
                // The I/O address shadows any RAM word at the same location.
                if (cpu_addr == IO_ADDR) begin
                    push = 1'b1;
                end else if (addr_in_ram) begin
                    ram_we = 1'b1;
                end
            end
        endcase
        cpu_rst_d   = (state_d != Run);
        boot_done_d = (state_d == Run);
        ovf_d       = ovf_q | (push & fifo_full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LoadCnt;
            cnt_q       <= 8'd0;
            ctr_q       <= 8'd0;
            hi_q        <= 8'd0;
            cpu_rst_q   <= 1'b1;
            boot_done_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctr_q       <= ctr_d;
            hi_q        <= hi_d;
            cpu_rst_q   <= cpu_rst_d;
            boot_done_q <= boot_done_d;
            ovf_q       <= ovf_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    always_comb begin
        cpu_rdata = 16'h0000;
        if (state_q == Run && cpu_addr == IO_ADDR) begin
            cpu_rdata = {13'b0, ovf_q, fifo_full, fifo_empty};
        end else if (addr_in_ram) begin
            cpu_rdata = ram[AW'(cpu_addr)];
        end
    end

    sync_fifo #(
        .W    (8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(cpu_wdata[7:0]),
        .full (fifo_full),
        .empty(fifo_empty),
        .head (out_data)
    );

endmodule

// File: tb/tb_mem_boot_io.sv
// Self-checking bench for mem_boot_io: directed boot/I-O scenarios plus a randomized run phase
// against a queue/array reference model.
module tb_mem_boot_io;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_ready;
    logic        cpu_rst;
    logic        boot_done;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_ram [256];
    logic [7:0]  fifo_q [$];
    bit          ref_ovf;
    logic [15:0] img [$];

    always #5 clk = ~clk;

    mem_boot_io dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .cpu_rst   (cpu_rst),
        .boot_done (boot_done),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        load_valid = 1'b1;
        load_data  = b;
        tick();
        load_valid = 1'b0;
        load_data  = 8'($urandom);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        load_valid = 1'b0;
        cpu_we     = 1'b0;
        out_ready  = 1'b0;
        settle();
        chk("reset_ctrl", {13'b0, load_ready, boot_done, cpu_rst}, 16'h0005);
        chk("reset_fifo", {7'b0, out_valid, out_data}, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        fifo_q.delete();
        ref_ovf = 1'b0;
    endtask

    // Boot an image of img.size() words, with random idle gaps between bytes.
    task automatic boot_img();
        send(8'(img.size()));
        for (int i = 0; i < img.size(); i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send(img[i][15:8]);
            repeat ($urandom_range(0, 2)) tick();
            settle();
            chk("boot_pending", {14'b0, boot_done, cpu_rst}, 16'h0001);
            send(img[i][7:0]);
            ref_ram[i] = img[i];
        end
        settle();
        chk("boot_done", {13'b0, load_ready, boot_done, cpu_rst}, 16'h0002);
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        cpu_we   = 1'b0;
        cpu_addr = a;
        settle();
        chk(tag, cpu_rdata, exp);
        tick();
    endtask

    // Write with out_ready low, so the model needs no same-cycle pop.
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        tick();
        cpu_we = 1'b0;
        if (a == 16'h00FF) begin
            if (fifo_q.size() == 4) ref_ovf = 1'b1;
            else fifo_q.push_back(d[7:0]);
        end else if (a < 16'h0100) begin
            ref_ram[a[7:0]] = d;
        end
    endtask

    function automatic logic [15:0] status();
        return {13'b0, ref_ovf, fifo_q.size() == 4, fifo_q.size() == 0};
    endfunction

    initial begin
        logic [15:0] a;
        logic [7:0]  exp_b;
        bit          full, we;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        cpu_we     = 1'b0;
        cpu_addr   = 16'h0000;
        cpu_wdata  = 16'h0000;
        out_ready  = 1'b0;
        tick();

        // Bytes 02 C1 2A 77 77.
        do_reset();
        img = {16'hC12A, 16'h7777};
        boot_img();
        rd("ram0", 16'h0000, 16'hC12A);
        rd("ram1", 16'h0001, 16'h7777);

        // Random image.
        do_reset();
        img.delete();
        repeat ($urandom_range(3, 8)) img.push_back(16'($urandom));
        boot_img();
        for (int i = 0; i < img.size(); i++) rd("rand_boot", 16'(i), ref_ram[i]);

        // Single push and pop.
        wr(16'h00FF, 16'h0041);
        settle();
        chk("push_vis", {7'b0, out_valid, out_data}, 16'h0141);
        rd("status_one", 16'h00FF, status());
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        void'(fifo_q.pop_front());
        settle();
        chk("pop_empty", {15'b0, out_valid}, 16'h0000);
        rd("status_empty", 16'h00FF, 16'h0001);

        // Overflow: fifth push dropped.
        wr(16'h00FF, 16'h0011);
        wr(16'h00FF, 16'h0022);
        wr(16'h00FF, 16'h0033);
        wr(16'h00FF, 16'h0044);
        wr(16'h00FF, 16'h0055);
        rd("status_ovf", 16'h00FF, 16'h0006);
        while (fifo_q.size() != 0) begin
            exp_b = fifo_q.pop_front();
            settle();
            chk("drain", {7'b0, out_valid, out_data}, {7'b0, 1'b1, exp_b});
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        rd("status_drained", 16'h00FF, 16'h0005);

        wr(16'h0010, 16'hBEEF);
        rd("ram_beef", 16'h0010, 16'hBEEF);
        wr(16'h0123, 16'h1234);
        rd("out_of_range", 16'h0123, 16'h0000);

        // Count 00: immediate run, RAM kept.
        do_reset();
        send(8'h00);
        settle();
        chk("zero_boot", {13'b0, load_ready, boot_done, cpu_rst}, 16'h0002);
        rd("ram_kept", 16'h0010, 16'hBEEF);

        // Randomized run phase.
        for (int i = 0; i < 16; i++) wr(16'(i), 16'($urandom));
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = 16'h00FF;
                2:       a = 16'($urandom_range(0, 15));
                default: a = 16'h0100 + 16'($urandom_range(0, 16'hFEFF));
            endcase
            we        = 1'($urandom_range(0, 1));
            cpu_we    = we;
            cpu_addr  = a;
            cpu_wdata = 16'($urandom);
            out_ready = ($urandom_range(0, 3) == 0);
            settle();
            if (a == 16'h00FF)     chk("rnd_status", cpu_rdata, status());
            else if (a < 16'h0100) chk("rnd_ram", cpu_rdata, ref_ram[a[7:0]]);
            else                   chk("rnd_oor", cpu_rdata, 16'h0000);
            chk("rnd_valid", {15'b0, out_valid}, {15'b0, fifo_q.size() != 0});
            if (fifo_q.size() != 0) chk("rnd_head", {8'b0, out_data}, {8'b0, fifo_q[0]});
            full = (fifo_q.size() == 4);
            if (out_ready && fifo_q.size() != 0) void'(fifo_q.pop_front());
            if (we) begin
                if (a == 16'h00FF) begin
                    if (full) ref_ovf = 1'b1;
                    else fifo_q.push_back(cpu_wdata[7:0]);
                end else if (a < 16'h0100) begin
                    ref_ram[a[7:0]] = cpu_wdata;
                end
            end
            tick();
        end
        cpu_we    = 1'b0;
        out_ready = 1'b0;
        rd("rnd_final", 16'h00FF, status());

        // Reset mid-boot after count 03 and one word; next byte is a fresh count.
        do_reset();
        send(8'h03);
        send(8'hAB);
        send(8'hCD);
        rst = 1'b1;
        settle();
        chk("midboot_rst", {13'b0, load_ready, boot_done, cpu_rst}, 16'h0005);
        tick();
        rst = 1'b0;
        tick();
        img = {16'hDEAD};
        boot_img();
        rd("fresh_word", 16'h0000, 16'hDEAD);
        rd("partial_kept", 16'h0001, ref_ram[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
